// File: rtl/hub2ieee_conv_if.sv
// Streaming bus for hub2ieee_conv: HUB words in, IEEE 754 words plus status flags out.
// The slave modport is the converter's view and the master modport is the driver's view.
interface hub2ieee_conv_if #(
  parameter int M = 23,
  parameter int E = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [E+M:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [E+M:0]   out_data;
  logic [2:0]     out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/hub2ieee_conv.sv
// Two-stage elastic HUB-to-IEEE 754 converter with round-to-nearest-even and status flags.
// Define HUB2IEEE_SUBNORM_EN to emit subnormals for tiny inputs; otherwise they flush to zero.
module hub2ieee_conv #(
  parameter int M = 23,
  parameter int E = 8
) (
  input logic             clk,
  input logic             rst,
  hub2ieee_conv_if.slave  bus
);
  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_TINY, CLS_NORM} cls_t;

  localparam logic [E-1:0] EXP_ONE = {{(E-1){1'b0}}, 1'b1};
  localparam logic [E-1:0] EXP_MAX = {E{1'b1}};

  logic           s1_valid;
  logic           s1_sign;
  logic [E-1:0]   s1_exp;
  logic [M-1:0]   s1_man;
  cls_t           s1_cls;

  logic           s2_valid;
  logic [E+M:0]   s2_data;
  logic [2:0]     s2_flags;

  logic           advance;
  logic [E-1:0]   in_exp;
  cls_t           in_cls;

  logic [M:0]     man_inc;
  logic [E-1:0]   exp_dec;
  logic [E-1:0]   conv_exp;
  logic [M-1:0]   conv_frac;
  logic [2:0]     conv_flags;

  assign advance      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || advance;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_flags = s2_flags;

  assign in_exp = bus.in_data[E+M-1:M];

  always_comb begin
    in_cls = CLS_NORM;
    if (in_exp == '0)
      in_cls = CLS_ZERO;
    else if (in_exp == EXP_MAX)
      in_cls = CLS_INF;
    else if (in_exp == EXP_ONE)
      in_cls = CLS_TINY;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      s1_sign <= bus.in_data[E+M];
      s1_exp  <= in_exp;
      s1_man  <= bus.in_data[M-1:0];
      s1_cls  <= in_cls;
    end
  end

  // The HUB value sits exactly halfway between m and m+1ulp, so RNE only looks at m[0].
  assign man_inc = {1'b0, s1_man} + {{M{1'b0}}, 1'b1};
  assign exp_dec = s1_exp - EXP_ONE;

`ifdef HUB2IEEE_SUBNORM_EN
  logic [M-1:0] sub_base;
  logic [M:0]   sub_inc;

  assign sub_base = {1'b1, s1_man[M-1:1]};
  assign sub_inc  = {1'b0, sub_base} + {{M{1'b0}}, 1'b1};
`endif

  always_comb begin
    conv_exp   = '0;
    conv_frac  = '0;
    conv_flags = 3'b000;
    case (s1_cls)
      CLS_ZERO: begin
        conv_exp = '0;
      end
      CLS_INF: begin
        conv_exp   = EXP_MAX;
        conv_flags = 3'b100;
      end
      CLS_TINY: begin
`ifdef HUB2IEEE_SUBNORM_EN
        if (s1_man[0]) begin
          conv_flags = 3'b010;
          if (sub_inc[M]) begin
            conv_exp  = EXP_ONE;
            conv_frac = '0;
          end else begin
            conv_frac = sub_inc[M-1:0];
          end
        end else begin
          conv_frac = sub_base;
        end
`else
        conv_flags = 3'b001;
`endif
      end
      CLS_NORM: begin
        if (s1_man[0]) begin
          conv_flags = 3'b010;
          if (man_inc[M]) begin
            conv_exp  = s1_exp;
            conv_frac = '0;
          end else begin
            conv_exp  = exp_dec;
            conv_frac = man_inc[M-1:0];
          end
        end else begin
          conv_exp  = exp_dec;
          conv_frac = s1_man;
        end
      end
      default: begin
        conv_exp = '0;
      end
    endcase
  end

  // Both stages move together whenever S2 is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flags <= 3'b000;
    end else begin
      if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= {s1_sign, conv_exp, conv_frac};
          s2_flags <= conv_flags;
        end
      end
    end
  end
endmodule

// File: tb/tb_hub2ieee_conv.sv
// Directed self-checking bench for hub2ieee_conv: conversions, latency, backpressure, reset flush.
// Expected tiny-input results follow HUB2IEEE_SUBNORM_EN when it is defined.
module tb_hub2ieee_conv;
  localparam int M = 23;
  localparam int E = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hub2ieee_conv_if #(.M(M), .E(E)) bus ();

  hub2ieee_conv #(.M(M), .E(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] bp_in  [5];
  logic [31:0] bp_exp [5];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Enters and leaves one time unit after a rising edge; returns after the transfer edge.
  task automatic applyStimulus(input logic [31:0] word);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    for (int c = 0; c < 20; c++) begin
      #1;
      got = bus.in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $error("[TB] FAIL accept_timeout: observed in_ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic convertOne(input string tag, input logic [31:0] word,
                            input logic [31:0] exp_data, input logic [2:0] exp_flags);
    applyStimulus(word);
    checkOutput({tag, "_early"}, {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    checkOutput({tag, "_data"}, bus.out_data, exp_data);
    checkOutput({tag, "_flags"}, {29'b0, bus.out_flags}, {29'b0, exp_flags});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, received, first_cyc, last_cyc;
    logic acc, outx, saw_valid;
    logic [31:0] cap_data;
    logic [2:0]  cap_flags;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_out_flags", {29'b0, bus.out_flags}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    convertOne("two_point_five", 32'h40A00000, 32'h40200000, 3'b000);
    convertOne("round_up", 32'h40000001, 32'h3F800002, 3'b010);
    convertOne("carry_exp", 32'h7F7FFFFF, 32'h7F000000, 3'b010);
    convertOne("even_keep", 32'hC0400002, 32'hBFC00002, 3'b000);
    convertOne("min_normal", 32'h01000001, 32'h00800002, 3'b010);
    convertOne("neg_inf", 32'hFFC12345, 32'hFF800000, 3'b100);
    convertOne("neg_zero", 32'h80012345, 32'h80000000, 3'b000);
`ifdef HUB2IEEE_SUBNORM_EN
    convertOne("tiny_zero_man", 32'h00800000, 32'h00400000, 3'b000);
    convertOne("tiny_all_ones", 32'h00FFFFFF, 32'h00800000, 3'b010);
    convertOne("tiny_neg_odd", 32'h80800001, 32'h80400001, 3'b010);
`else
    convertOne("tiny_zero_man", 32'h00800000, 32'h00000000, 3'b001);
    convertOne("tiny_all_ones", 32'h00FFFFFF, 32'h00000000, 3'b001);
    convertOne("tiny_neg_odd", 32'h80800001, 32'h80000000, 3'b001);
`endif

    // Backpressure: five words offered back to back while the output is stalled.
    for (int k = 0; k < 5; k++) begin
      bp_in[k]  = 32'h40000000 + 32'(2 * k);
      bp_exp[k] = 32'h3F800000 + 32'(2 * k);
    end
    bus.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bp_in[sent];
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    checkOutput("bp_accepted", 32'(sent), 32'd2);
    checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("bp_hold_data", bus.out_data, bp_exp[0]);

    bus.out_ready = 1'b1;
    received  = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = (sent < 5);
      bus.in_data  = (sent < 5) ? bp_in[sent] : 32'd0;
      #1;
      acc       = bus.in_valid && bus.in_ready;
      outx      = bus.out_valid;
      cap_data  = bus.out_data;
      cap_flags = bus.out_flags;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (outx) begin
        if (received < 5) begin
          checkOutput($sformatf("bp_out%0d_data", received), cap_data, bp_exp[received]);
          checkOutput($sformatf("bp_out%0d_flags", received), {29'b0, cap_flags}, 32'd0);
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        received++;
      end
      if (received >= 5 && sent >= 5) break;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_sent_total", 32'(sent), 32'd5);
    checkOutput("bp_received_total", 32'(received), 32'd5);
    checkOutput("bp_back_to_back", 32'(last_cyc - first_cyc), 32'd4);
    @(posedge clk);
    #1;

    // Fill both stages, then pulse reset for one cycle.
    bus.out_ready = 1'b0;
    applyStimulus(32'h40A00000);
    applyStimulus(32'h40000001);
    checkOutput("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("flush_no_stale", {31'b0, saw_valid}, 32'd0);
    convertOne("after_flush", 32'h40A00000, 32'h40200000, 3'b000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
